// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller between two requesters with round-robin or port-0-priority grant.
module sram_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en0,
  input  logic        wr_en0,
  input  logic [31:0] address0,
  input  logic [31:0] write_data0,
  output logic [31:0] read_data0,
  output logic        ready0,
  input  logic        rd_en1,
  input  logic        wr_en1,
  input  logic [31:0] address1,
  input  logic [31:0] write_data1,
  output logic [31:0] read_data1,
  output logic        ready1,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;
  state_e      state_q, state_d;
  logic        last_q, last_d, op_rd_q, op_rd_d, req0, req1, win1;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] rd_hold0_q, rd_hold0_d, rd_hold1_q, rd_hold1_d;
  assign req0 = rd_en0 | wr_en0;
  assign req1 = rd_en1 | wr_en1;
  // Port 1 wins when alone, or on a tie when round-robin and port 0 was served last
  assign win1 = req1 & (~req0 | (ROUND_ROBIN & ~last_q));
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    op_rd_d    = op_rd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_hold0_d = rd_hold0_q;
    rd_hold1_d = rd_hold1_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = win1 ? GRANT1 : GRANT0;
        op_rd_d = win1 ? rd_en1 : rd_en0;
        addr_d  = win1 ? address1 : address0;
        wdata_d = win1 ? write_data1 : write_data0;
      end
      GRANT0: if (mem_ready) begin
        state_d    = IDLE;
        last_d     = 1'b0;
        rd_hold0_d = op_rd_q ? mem_read_data : rd_hold0_q;
      end
      GRANT1: if (mem_ready) begin
        state_d    = IDLE;
        last_d     = 1'b1;
        rd_hold1_d = op_rd_q ? mem_read_data : rd_hold1_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      op_rd_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_hold0_q <= '0;
      rd_hold1_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      op_rd_q    <= op_rd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_hold0_q <= rd_hold0_d;
      rd_hold1_q <= rd_hold1_d;
    end
  end
  assign busy           = state_q != IDLE;
  assign mem_rd_en      = busy & op_rd_q;
  assign mem_wr_en      = busy & ~op_rd_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign ready0         = (state_q == GRANT0) & mem_ready;
  assign ready1         = (state_q == GRANT1) & mem_ready;
  assign read_data0     = (ready0 & op_rd_q) ? mem_read_data : rd_hold0_q;
  assign read_data1     = (ready1 & op_rd_q) ? mem_read_data : rd_hold1_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of a round-robin and a fixed-priority arbiter, each with its own SRAM controller model.
module tb_sram_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic rd_en0 = 0, wr_en0 = 0, rd_en1 = 0, wr_en1 = 0;
  logic [31:0] address0 = 0, write_data0 = 0, address1 = 0, write_data1 = 0;
  logic [31:0] read_data0, read_data1, mem_address, mem_write_data, mem_read_data;
  logic ready0, ready1, mem_rd_en, mem_wr_en, mem_ready, busy;
  logic [31:0] p_read_data0, p_read_data1, p_mem_address, p_mem_write_data, p_mem_read_data;
  logic p_ready0, p_ready1, p_mem_rd_en, p_mem_wr_en, p_mem_ready, p_busy;
  logic [2:0] cnt_a, cnt_b;
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a == 32'h408) ? 32'hDEAD_BEEF : (a ^ 32'hA5A5_0000);
  endfunction
  // Controller model: ready pulses in the 6th cycle of a held enable
  always @(posedge clk) cnt_a <= (rst || mem_ready) ? 3'd0 : (mem_rd_en | mem_wr_en) ? cnt_a + 3'd1 : cnt_a;
  always @(posedge clk) cnt_b <= (rst || p_mem_ready) ? 3'd0 : (p_mem_rd_en | p_mem_wr_en) ? cnt_b + 3'd1 : cnt_b;
  assign mem_ready       = (mem_rd_en | mem_wr_en) && cnt_a == 3'd5;
  assign p_mem_ready     = (p_mem_rd_en | p_mem_wr_en) && cnt_b == 3'd5;
  assign mem_read_data   = mem_rd_en ? f(mem_address) : 32'hBAD0_BAD0;
  assign p_mem_read_data = p_mem_rd_en ? f(p_mem_address) : 32'hBAD0_BAD0;
  sram_arbiter #(.ROUND_ROBIN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .rd_en0(rd_en0), .wr_en0(wr_en0), .address0(address0), .write_data0(write_data0),
    .read_data0(read_data0), .ready0(ready0),
    .rd_en1(rd_en1), .wr_en1(wr_en1), .address1(address1), .write_data1(write_data1),
    .read_data1(read_data1), .ready1(ready1),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .mem_ready(mem_ready), .busy(busy));
  sram_arbiter #(.ROUND_ROBIN(1'b0)) dut_p (
    .clk(clk), .rst(rst),
    .rd_en0(rd_en0), .wr_en0(wr_en0), .address0(address0), .write_data0(write_data0),
    .read_data0(p_read_data0), .ready0(p_ready0),
    .rd_en1(rd_en1), .wr_en1(wr_en1), .address1(address1), .write_data1(write_data1),
    .read_data1(p_read_data1), .ready1(p_ready1),
    .mem_rd_en(p_mem_rd_en), .mem_wr_en(p_mem_wr_en), .mem_address(p_mem_address),
    .mem_write_data(p_mem_write_data), .mem_read_data(p_mem_read_data), .mem_ready(p_mem_ready), .busy(p_busy));
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    ncmp++; if ({busy, ready0, ready1, mem_rd_en, mem_wr_en} !== 5'b0) begin nerr++; $display("FAIL reset_ctrl got %b want 00000", {busy, ready0, ready1, mem_rd_en, mem_wr_en}); end
    ncmp++; if (mem_address !== 32'h0) begin nerr++; $display("FAIL reset_addr got %h want 0", mem_address); end
    ncmp++; if (mem_write_data !== 32'h0) begin nerr++; $display("FAIL reset_wdata got %h want 0", mem_write_data); end
    ncmp++; if ({read_data0, read_data1} !== 64'h0) begin nerr++; $display("FAIL reset_rdata got %h want 0", {read_data0, read_data1}); end
  endtask
  task automatic test_read0;
    address0 = 32'h408;
    rd_en0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      ncmp++; if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0) begin nerr++; $display("FAIL read0_en c%0d got rd=%b wr=%b want rd=1 wr=0", i, mem_rd_en, mem_wr_en); end
      ncmp++; if (mem_address !== 32'h408) begin nerr++; $display("FAIL read0_addr c%0d got %h want 408", i, mem_address); end
      ncmp++; if (ready0 !== (i == 6) || ready1 !== 1'b0) begin nerr++; $display("FAIL read0_ready c%0d got r0=%b r1=%b want r0=%b r1=0", i, ready0, ready1, i == 6); end
    end
    ncmp++; if (read_data0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL read0_data got %h want deadbeef", read_data0); end
    rd_en0 = 1'b0;
    address0 = 32'h0;
    tick();
    ncmp++; if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin nerr++; $display("FAIL read0_idle got busy=%b rd=%b want 0 0", busy, mem_rd_en); end
    ncmp++; if (read_data0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL read0_hold got %h want deadbeef", read_data0); end
  endtask
  task automatic test_write1;
    address1 = 32'h500;
    write_data1 = 32'h1234_5678;
    wr_en1 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      ncmp++; if (mem_wr_en !== 1'b1 || mem_rd_en !== 1'b0) begin nerr++; $display("FAIL write1_en c%0d got wr=%b rd=%b want wr=1 rd=0", i, mem_wr_en, mem_rd_en); end
      ncmp++; if (mem_write_data !== 32'h1234_5678 || mem_address !== 32'h500) begin nerr++; $display("FAIL write1_bus c%0d got %h@%h want 12345678@500", i, mem_write_data, mem_address); end
      ncmp++; if (ready1 !== (i == 6) || ready0 !== 1'b0) begin nerr++; $display("FAIL write1_ready c%0d got r1=%b r0=%b want r1=%b r0=0", i, ready1, ready0, i == 6); end
    end
    ncmp++; if (read_data1 !== 32'h0) begin nerr++; $display("FAIL write1_rdata got %h want 0", read_data1); end
    wr_en1 = 1'b0;
    tick();
    ncmp++; if (busy !== 1'b0 || read_data1 !== 32'h0) begin nerr++; $display("FAIL write1_idle got busy=%b rd1=%h want 0 0", busy, read_data1); end
  endtask
  task automatic test_contention;
    address0 = 32'h100;
    address1 = 32'h200;
    rd_en0 = 1'b1;
    rd_en1 = 1'b1;
    for (int i = 1; i <= 27; i++) begin
      tick();
      ncmp++; if (ready0 !== (i == 6 || i == 20) || ready1 !== (i == 13 || i == 27)) begin nerr++; $display("FAIL rr_order c%0d got r0=%b r1=%b want r0=%b r1=%b", i, ready0, ready1, i == 6 || i == 20, i == 13 || i == 27); end
      ncmp++; if (p_ready0 !== (i % 7 == 6) || p_ready1 !== 1'b0) begin nerr++; $display("FAIL prio_order c%0d got r0=%b r1=%b want r0=%b r1=0", i, p_ready0, p_ready1, i % 7 == 6); end
      if (i == 20) begin ncmp++; if (read_data0 !== f(32'h100)) begin nerr++; $display("FAIL rr_data0 got %h want %h", read_data0, f(32'h100)); end end
      if (i == 27) begin ncmp++; if (read_data1 !== f(32'h200)) begin nerr++; $display("FAIL rr_data1 got %h want %h", read_data1, f(32'h200)); end end
    end
    rd_en0 = 1'b0;
    rd_en1 = 1'b0;
    repeat (7) tick();
    ncmp++; if (busy !== 1'b0 || p_busy !== 1'b0) begin nerr++; $display("FAIL contention_idle got %b%b want 00", busy, p_busy); end
  endtask
  task automatic test_capture;
    address0 = 32'h408;
    rd_en0 = 1'b1;
    wr_en0 = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 2) begin address0 = 32'h600; write_data0 = 32'hFFFF_0000; wr_en0 = 1'b0; end
      ncmp++; if (mem_rd_en !== 1'b1 || mem_wr_en !== 1'b0) begin nerr++; $display("FAIL cap_op c%0d got rd=%b wr=%b want rd=1 wr=0", i, mem_rd_en, mem_wr_en); end
      ncmp++; if (mem_address !== 32'h408) begin nerr++; $display("FAIL cap_addr c%0d got %h want 408", i, mem_address); end
    end
    ncmp++; if (ready0 !== 1'b1 || read_data0 !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL cap_done got r0=%b %h want 1 deadbeef", ready0, read_data0); end
    rd_en0 = 1'b0;
    tick();
  endtask
  task automatic test_reset_mid;
    address0 = 32'h300;
    rd_en0 = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    ncmp++; if (busy !== 1'b0 || mem_rd_en !== 1'b0 || ready0 !== 1'b0) begin nerr++; $display("FAIL rstmid_idle got busy=%b rd=%b r0=%b want 0 0 0", busy, mem_rd_en, ready0); end
    rst = 1'b0;
    tick();
    ncmp++; if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_address !== 32'h300) begin nerr++; $display("FAIL rstmid_regrant got busy=%b rd=%b a=%h want 1 1 300", busy, mem_rd_en, mem_address); end
    for (int i = 2; i <= 6; i++) begin
      tick();
      ncmp++; if (ready0 !== (i == 6)) begin nerr++; $display("FAIL rstmid_ready c%0d got %b want %b", i, ready0, i == 6); end
    end
    ncmp++; if (read_data0 !== f(32'h300)) begin nerr++; $display("FAIL rstmid_data got %h want %h", read_data0, f(32'h300)); end
    rd_en0 = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_read0();
    test_write1();
    test_contention();
    test_capture();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single SRAM controller between two memory requesters, such as a data-memory port and a DMA/debug port. It captures one requester's operation, address and write data, then drives the SRAM controller until that controller's one-cycle `ready` pulse. It returns the result and `ready` to the granted port only. Grant is round-robin by default, with optional fixed priority for port 0.

## Interface
- `ROUND_ROBIN`, default 1: 1 = alternate priority after each service; 0 = port 0 always wins ties.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `rd_en0` / `wr_en0` in 1 each: port 0 request; level, held until `ready0`.
- `address0` in 32: port 0 byte address.
- `write_data0` in 32: port 0 write data.
- `read_data0` out 32: port 0 read result.
- `ready0` out 1: port 0 completion pulse, 1 cycle.
- `rd_en1`, `wr_en1`, `address1`, `write_data1`, `read_data1`, `ready1`: port 1, identical to port 0.
- `mem_rd_en` / `mem_wr_en` out 1 each: to SRAM controller.
- `mem_address` out 32: to SRAM controller.
- `mem_write_data` out 32: to SRAM controller.
- `mem_read_data` in 32: from SRAM controller.
- `mem_ready` in 1: from SRAM controller; one-cycle pulse at end of each access.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- **IDLE**
  - `mem_rd_en` = `mem_wr_en` = 0.
  - Port k is requesting if `rd_en_k | wr_en_k`.
  - Winner selection: if only one port requests, it wins. If both request and `ROUND_ROBIN` = 1, the port not equal to `last` wins; if `ROUND_ROBIN` = 0, port 0 wins.
  - On a winner, the next state is GRANTk.
  - On that same edge, capture `op_rd` = `rd_en_k` (read beats write if both are set), `addr_q` = `address_k` and `wdata_q` = `write_data_k`.
- **GRANTk**
  - `mem_rd_en` = `op_rd`, `mem_wr_en` = ~`op_rd`.
  - `mem_address` = `addr_q`, `mem_write_data` = `wdata_q`; these stay stable for the whole grant.
  - `ready_k` = `mem_ready`; the other port's ready = 0.
  - When `mem_ready` = 1: next state IDLE, `last` <= k, and `rd_hold_k` <= `mem_read_data`, loaded for reads only.
- `read_data_k` = (`ready_k` & read) ? `mem_read_data` : `rd_hold_k`. The value is valid in the `ready_k` cycle and holds until the next read completes on that port.
- Requester changes to address, data or enables after the grant do not affect the captured transaction.
- A port's request seen in the cycle after its `ready` is treated as a new request.
- `mem_ready` while in IDLE is ignored.
- Reset values:
  - State = IDLE, `last` = 1 (port 0 wins the first tie).
  - `op_rd` = 0, `addr_q` = 0, `wdata_q` = 0, `rd_hold0` = `rd_hold1` = 0.
  - Resulting outputs: `ready0` = `ready1` = 0, `mem_rd_en` = `mem_wr_en` = 0, `busy` = 0, `mem_address` = 0, `mem_write_data` = 0.

## Timing
- Request visible in IDLE at cycle T → GRANTk at T+1, enable reaches the controller at T+1.
- The controller spends 5 cycles in its access sequence, so `mem_ready` and `ready_k` arrive at T+6 for both reads and writes.
- After `ready` at T+6, the arbiter is in IDLE at T+7 with enables low. The controller is idle at T+7 and cannot restart a stale request.
- Back-to-back transactions: one every 7 cycles, next `ready` at T+13.
- Grant decision is registered; `ready_k` and `read_data_k` (in the ready cycle) are combinational from `mem_ready` and `mem_read_data`.
- Reset mid-grant: the arbiter is in IDLE on the next cycle and no `ready` pulse is issued for the aborted access. The SRAM controller shares `rst` and resets concurrently.
- Requesters must hold their enable until their `ready`. Dropping the enable early does not cancel the captured access; its result is still delivered.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0, `busy` = 0, `mem_address` = 0.
- **Single read, port 0:** `rd_en0` = 1, `address0` = 0x408 held; model returns 0xDEADBEEF → `mem_rd_en` high T+1..T+6, `mem_address` = 0x408, `ready0` pulses at T+6 with `read_data0` = 0xDEADBEEF, `ready1` stays 0, `read_data0` remains 0xDEADBEEF afterwards.
- **Write, port 1:** `wr_en1`, `address1` = 0x500, `write_data1` = 0x12345678 → `mem_wr_en` high, `mem_write_data` = 0x12345678, `ready1` at T+6, `read_data1` unchanged (0).
- **Simultaneous contention, `ROUND_ROBIN` = 1, both hold requests:** service order 0,1,0,1; `ready` pulses at T+6, T+13, T+20, T+27. With `ROUND_ROBIN` = 0 and both always requesting, port 0 is served repeatedly.
- **Capture and stability:** change `address0` to 0x600 two cycles after grant → `mem_address` stays 0x408 until `ready0`; both `rd_en0` and `wr_en0` set → read performed.
- **Reset mid-operation:** assert `rst` at T+3 of a grant → IDLE next cycle, `mem_rd_en` = 0, no `ready0`; the request is re-granted (GRANT0 at T+5) if it is still held after reset is released at T+4.
